// File: rtl/bsg_link_ddr_upstream_piso.sv
// bsg_link_ddr_upstream_piso
// Transmit-side serializer for a DDR source-synchronous link. Core words are
// buffered in a 2-entry queue and sent as ddr_width_p chunks, least
// significant chunk first, matching the chunk order of the receive-side SIPO.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// when valid and ready are both high. A producer holds valid and data stable
// until the transfer. ready_o is a function of registered state only (gated
// by reset), and v_o/data_o/last_o never look at ready_i.
module bsg_link_ddr_upstream_piso #(
  parameter int width_p = 64,
  parameter int channel_width_p = 8,
  localparam int ddr_width_p = 2 * channel_width_p,
  localparam int piso_ratio_p = width_p / ddr_width_p
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [width_p-1:0]     data_i,
  input  logic                   v_i,
  output logic                   ready_o,
  output logic [ddr_width_p-1:0] data_o,
  output logic                   v_o,
  output logic                   last_o,
  input  logic                   ready_i
);

  localparam int cnt_w = (piso_ratio_p > 1) ? $clog2(piso_ratio_p) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(piso_ratio_p - 1);

  // A word must split into at least two whole chunks.
  if ((piso_ratio_p < 2) || ((width_p % ddr_width_p) != 0)) begin : g_bad_params
    $error("bsg_link_ddr_upstream_piso: width_p must be a multiple of 2*channel_width_p with ratio >= 2");
  end

  logic [1:0][width_p-1:0]                   mem;
  logic [1:0]                                occ;
  logic [1:0]                                occ_next;
  logic                                      rptr;
  logic                                      wptr;
  logic [cnt_w-1:0]                          cnt;
  logic                                      full;
  logic                                      enq;
  logic                                      xfer;
  logic                                      last_xfer;
  logic [piso_ratio_p-1:0][ddr_width_p-1:0]  head_chunks;

  // Reset gating keeps ready_o low while reset is asserted; otherwise it only
  // depends on the occupancy flops, so a dequeue in a full cycle does not
  // raise it until the next cycle.
  assign full      = &occ;
  assign ready_o   = reset_n_i & ~full;
  assign enq       = v_i & ready_o;

  assign v_o         = occ[rptr];
  assign head_chunks = mem[rptr];
  assign data_o      = head_chunks[cnt];
  assign last_o      = v_o & (cnt == cnt_last);
  assign xfer        = v_o & ready_i;
  assign last_xfer   = xfer & (cnt == cnt_last);

  // Next occupancy: an enqueue and a final-chunk dequeue can land together;
  // they always target different entries because enqueue needs a free slot.
  always_comb begin
    occ_next = occ;
    if (enq) occ_next[wptr] = 1'b1;
    if (last_xfer) occ_next[rptr] = 1'b0;
  end

  // Buffer storage, pointers and chunk counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem  <= '0;
      occ  <= '0;
      rptr <= 1'b0;
      wptr <= 1'b0;
      cnt  <= '0;
    end else begin
      if (enq) begin
        mem[wptr] <= data_i;
        wptr      <= ~wptr;
      end
      if (xfer) begin
        cnt <= (cnt == cnt_last) ? '0 : cnt + 1'b1;
      end
      if (last_xfer) begin
        rptr <= ~rptr;
      end
      occ <= occ_next;
    end
  end

endmodule

// File: tb/tb_bsg_link_ddr_upstream_piso.sv
// Bench for bsg_link_ddr_upstream_piso with width_p=64, channel_width_p=8
// (16-bit chunks, 4 chunks per word). Inputs are driven and outputs observed
// on the falling edge; every transfer decision applies to the next rising edge.
module tb_bsg_link_ddr_upstream_piso;

  localparam int W  = 64;
  localparam int DW = 16;
  localparam int R  = 4;

  localparam logic [W-1:0] WORD_A = 64'h4444_3333_2222_1111;
  localparam logic [W-1:0] WORD_B = 64'h8888_7777_6666_5555;
  localparam logic [W-1:0] WORD_C = 64'hcccc_bbbb_aaaa_9999;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  data_i;
  logic          v_i;
  logic          ready_o;
  logic [DW-1:0] data_o;
  logic          v_o;
  logic          last_o;
  logic          ready_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  bsg_link_ddr_upstream_piso #(
    .width_p(64),
    .channel_width_p(8)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .data_i   (data_i),
    .v_i      (v_i),
    .ready_o  (ready_o),
    .data_o   (data_o),
    .v_o      (v_o),
    .last_o   (last_o),
    .ready_i  (ready_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected chunk k of word w (LSB chunk first).
  function automatic logic [DW-1:0] chunk(input logic [W-1:0] w, input int k);
    return w[k*DW +: DW];
  endfunction

  task automatic test_reset;
    rst_n   = 1'b0;
    v_i     = 1'b0;
    ready_i = 1'b0;
    data_i  = 'x;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if ({ready_o, v_o, last_o, data_o} !== 19'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: got rdy=%b v=%b last=%b data=%h, want all 0", ready_o, v_o, last_o, data_o);
      end
    end
    rst_n = 1'b1;
    // X on data_i while v_i is low must not reach storage.
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ready_o, v_o, last_o, data_o} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL post_reset: got rdy=%b v=%b last=%b data=%h, want rdy=1 v=0 last=0 data=0000", ready_o, v_o, last_o, data_o);
    end
  endtask

  task automatic test_single_word;
    @(negedge clk);
    data_i = WORD_A; v_i = 1'b1; ready_i = 1'b1;
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_fail++; $display("FAIL single_ready: got %b want 1", ready_o);
    end
    for (int k = 0; k < R; k++) begin
      @(negedge clk);
      v_i = 1'b0; data_i = 'x;
      n_checks++;
      if ({v_o, last_o, data_o} !== {1'b1, (k == R-1), chunk(WORD_A, k)}) begin
        n_fail++;
        $display("FAIL single_chunk%0d: got v=%b last=%b data=%h want v=1 last=%b data=%h",
                 k, v_o, last_o, data_o, (k == R-1), chunk(WORD_A, k));
      end
    end
    @(negedge clk);
    n_checks++;
    if ({v_o, last_o} !== 2'b00) begin
      n_fail++; $display("FAIL single_idle: got v=%b last=%b want 0 0", v_o, last_o);
    end
  endtask

  task automatic test_enq_on_last;
    @(negedge clk);
    data_i = WORD_A; v_i = 1'b1; ready_i = 1'b1;
    for (int j = 0; j < 2*R; j++) begin
      @(negedge clk);
      v_i = 1'b0; data_i = 'x;
      n_checks++;
      if ({v_o, last_o, data_o} !== {1'b1, (j % R == R-1), chunk((j < R) ? WORD_A : WORD_B, j % R)}) begin
        n_fail++;
        $display("FAIL enq_last_chunk%0d: got v=%b last=%b data=%h want v=1 last=%b data=%h",
                 j, v_o, last_o, data_o, (j % R == R-1), chunk((j < R) ? WORD_A : WORD_B, j % R));
      end
      if (j == R-1 || j == R) begin
        n_checks++;
        if (ready_o !== 1'b1) begin
          n_fail++; $display("FAIL enq_last_ready%0d: got %b want 1", j, ready_o);
        end
      end
      // Present B while A's final chunk is going out.
      if (j == R-1) begin
        data_i = WORD_B; v_i = 1'b1;
      end
    end
    @(negedge clk);
    n_checks++;
    if (v_o !== 1'b0) begin
      n_fail++; $display("FAIL enq_last_idle: got v=%b want 0", v_o);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] words[3];
    bit           exp_rdy[12];
    int           widx;
    logic         acc;
    words   = '{WORD_A, WORD_B, WORD_C};
    exp_rdy = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1};
    widx = 0;
    @(negedge clk);
    data_i = WORD_A; v_i = 1'b1; ready_i = 1'b1;
    acc = ready_o;
    for (int c = 1; c <= 3*R; c++) begin
      @(negedge clk);
      if (acc) widx++;
      if (widx < 3) begin
        data_i = words[widx]; v_i = 1'b1;
      end else begin
        data_i = 'x; v_i = 1'b0;
      end
      n_checks++;
      if ({v_o, last_o, data_o} !== {1'b1, ((c-1) % R == R-1), chunk(words[(c-1)/R], (c-1) % R)}) begin
        n_fail++;
        $display("FAIL b2b_chunk%0d: got v=%b last=%b data=%h want v=1 last=%b data=%h",
                 c-1, v_o, last_o, data_o, ((c-1) % R == R-1), chunk(words[(c-1)/R], (c-1) % R));
      end
      n_checks++;
      if (ready_o !== exp_rdy[c-1]) begin
        n_fail++; $display("FAIL b2b_ready%0d: got %b want %b", c-1, ready_o, exp_rdy[c-1]);
      end
      acc = v_i & ready_o;
    end
    n_checks++;
    if (widx !== 3) begin
      n_fail++; $display("FAIL b2b_accepts: got %0d want 3", widx);
    end
    @(negedge clk);
    n_checks++;
    if (v_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: got v=%b want 0", v_o);
    end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] exp_d[10];
    exp_d = '{16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888,
              16'h9999, 16'haaaa, 16'hbbbb, 16'hcccc};
    @(negedge clk);
    data_i = WORD_A; v_i = 1'b1; ready_i = 1'b1;
    @(negedge clk);
    v_i = 1'b0; data_i = 'x;
    n_checks++;
    if (data_o !== 16'h1111) begin
      n_fail++; $display("FAIL bp_chunk0: got %h want 1111", data_o);
    end
    @(negedge clk);
    n_checks++;
    if ({v_o, last_o, data_o, ready_o} !== {1'b1, 1'b0, 16'h2222, 1'b1}) begin
      n_fail++; $display("FAIL bp_chunk1: got v=%b last=%b data=%h rdy=%b want 1 0 2222 1", v_o, last_o, data_o, ready_o);
    end
    ready_i = 1'b0; data_i = WORD_B; v_i = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      data_i = WORD_C; v_i = 1'b1;
      n_checks++;
      if ({v_o, last_o, data_o, ready_o} !== {1'b1, 1'b0, 16'h2222, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got v=%b last=%b data=%h rdy=%b want 1 0 2222 0", s, v_o, last_o, data_o, ready_o);
      end
    end
    ready_i = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (j == 3) begin
        v_i = 1'b0; data_i = 'x;
      end
      n_checks++;
      if ({v_o, last_o, data_o} !== {1'b1, (j % R == 1), exp_d[j]}) begin
        n_fail++;
        $display("FAIL bp_resume%0d: got v=%b last=%b data=%h want v=1 last=%b data=%h",
                 j, v_o, last_o, data_o, (j % R == 1), exp_d[j]);
      end
      if (j < 3) begin
        n_checks++;
        if (ready_o !== (j == 2)) begin
          n_fail++; $display("FAIL bp_ready%0d: got %b want %b", j, ready_o, (j == 2));
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (v_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_idle: got v=%b want 0", v_o);
    end
  endtask

  task automatic test_full_simultaneous;
    @(negedge clk);
    data_i = WORD_A; v_i = 1'b1; ready_i = 1'b0;
    @(negedge clk);
    data_i = WORD_B; v_i = 1'b1;
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_fail++; $display("FAIL full_ready_one: got %b want 1", ready_o);
    end
    @(negedge clk);
    v_i = 1'b0; data_i = 'x; ready_i = 1'b1;
    for (int j = 0; j < 2*R; j++) begin
      if (j > 0) @(negedge clk);
      n_checks++;
      if ({v_o, last_o, data_o} !== {1'b1, (j % R == R-1), chunk((j < R) ? WORD_A : WORD_B, j % R)}) begin
        n_fail++;
        $display("FAIL full_chunk%0d: got v=%b last=%b data=%h want v=1 last=%b data=%h",
                 j, v_o, last_o, data_o, (j % R == R-1), chunk((j < R) ? WORD_A : WORD_B, j % R));
      end
      n_checks++;
      if (ready_o !== (j >= R)) begin
        n_fail++; $display("FAIL full_ready%0d: got %b want %b", j, ready_o, (j >= R));
      end
    end
    @(negedge clk);
    n_checks++;
    if (v_o !== 1'b0) begin
      n_fail++; $display("FAIL full_idle: got v=%b want 0", v_o);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    data_i = WORD_A; v_i = 1'b1; ready_i = 1'b1;
    @(negedge clk);
    data_i = WORD_B; v_i = 1'b1;
    @(negedge clk);
    v_i = 1'b0; data_i = 'x;
    @(negedge clk);
    n_checks++;
    if (data_o !== 16'h3333) begin
      n_fail++; $display("FAIL arst_pre: got %h want 3333", data_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ready_o, v_o, last_o, data_o} !== 19'h0) begin
      n_fail++;
      $display("FAIL arst_immediate: got rdy=%b v=%b last=%b data=%h want all 0", ready_o, v_o, last_o, data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ready_o, v_o} !== 2'b10) begin
      n_fail++; $display("FAIL arst_release: got rdy=%b v=%b want 1 0", ready_o, v_o);
    end
    data_i = WORD_C; v_i = 1'b1; ready_i = 1'b1;
    for (int k = 0; k < R; k++) begin
      @(negedge clk);
      v_i = 1'b0; data_i = 'x;
      n_checks++;
      if ({v_o, last_o, data_o} !== {1'b1, (k == R-1), chunk(WORD_C, k)}) begin
        n_fail++;
        $display("FAIL arst_chunk%0d: got v=%b last=%b data=%h want v=1 last=%b data=%h",
                 k, v_o, last_o, data_o, (k == R-1), chunk(WORD_C, k));
      end
    end
    @(negedge clk);
    n_checks++;
    if (v_o !== 1'b0) begin
      n_fail++; $display("FAIL arst_idle: got v=%b want 0 (stale word after reset)", v_o);
    end
  endtask

  task automatic test_random;
    int           sent;
    int           recv;
    int           idx;
    logic [W-1:0] asmw;
    logic [W-1:0] exp_w;
    sent = 0; recv = 0; idx = 0; asmw = '0;
    for (int cyc = 0; cyc < 10200; cyc++) begin
      @(negedge clk);
      if (cyc < 10000) begin
        v_i     = ($urandom_range(0, 99) < 60);
        data_i  = v_i ? {$urandom, $urandom} : 'x;
        ready_i = ($urandom_range(0, 99) < 70);
      end else begin
        v_i = 1'b0; data_i = 'x; ready_i = 1'b1;
        if (exp_q.size() == 0 && idx == 0) break;
      end
      if (!v_o) begin
        n_checks++;
        if (last_o !== 1'b0) begin
          n_fail++; $display("FAIL rand_last_idle cyc %0d: got %b want 0", cyc, last_o);
        end
      end
      if (v_o && ready_i) begin
        n_checks++;
        if (last_o !== (idx == R-1)) begin
          n_fail++; $display("FAIL rand_last cyc %0d: got %b want %b", cyc, last_o, (idx == R-1));
        end
        asmw[idx*DW +: DW] = data_o;
        if (idx == R-1) begin
          idx = 0;
          recv++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL rand_extra cyc %0d: got word %h, want none", cyc, asmw);
          end else begin
            exp_w = exp_q.pop_front();
            if (asmw !== exp_w) begin
              n_fail++; $display("FAIL rand_word cyc %0d: got %h want %h", cyc, asmw, exp_w);
            end
          end
        end else begin
          idx++;
        end
      end
      if (v_i && ready_o) begin
        exp_q.push_back(data_i);
        sent++;
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || idx != 0 || recv != sent || sent == 0) begin
      n_fail++;
      $display("FAIL rand_drain: got recv=%0d pending=%0d partial=%0d, want recv=sent=%0d with none pending",
               recv, exp_q.size(), idx, sent);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_enq_on_last();
    test_back_to_back();
    test_backpressure();
    test_full_simultaneous();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
